spi_slave_regfile: RTL and testbench
====================================

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 SHALL have parameter: DEV_ID, 8'hA5, read-only value returned at address 7.
REQ-002 SHALL have parameter: RESET_VAL, 8'h00, reset value of registers 0-6.
REQ-003 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: cs  input  1  SPI chip select, active-low; cs=1 ends a frame.
REQ-006 SHALL have port: done_sl  input  1  one-cycle pulse; a byte was received from the SPI slave.
REQ-007 SHALL have port: data_rx_sl  input  8  received byte; valid when done_sl=1.
REQ-008 SHALL have port: data_tx_sl  output  8  byte the SPI slave shifts out on the next transfer.
REQ-009 SHALL have port: loc_addr  input  3  local-side read address.
REQ-010 SHALL have port: loc_rdata  output  8  combinational read of reg[loc_addr].
REQ-011 SHALL have port: wr_strobe  output  1  one-cycle pulse per accepted SPI write.
REQ-012 SHALL have port: wr_addr  output  3  address of the last accepted write; valid with wr_strobe.
REQ-013 SHALL have port: err_cnt  output  8  saturating protocol-error count.
REQ-014 SHALL have port: frame_active  output  1  high while state != IDLE.

Function
REQ-015 SHALL hold 8 registers: addresses 0-6 read/write, address 7 fixed at DEV_ID.
REQ-016 SHALL decode the first byte of each frame as a command: bit7=1 write, bit7=0 read; bits6:3 must be 0; bits2:0 are the start address.
REQ-017 SHALL implement the FSM states IDLE, WR_DATA, RD_DATA, DISCARD.
REQ-018 IDLE + done_sl with valid write command -> WR_DATA; latch addr.
REQ-019 IDLE + done_sl with valid read command -> RD_DATA; latch addr; data_tx_sl <= reg[addr] on the next clk edge.
REQ-020 IDLE + done_sl with bits6:3 != 0 -> DISCARD; err_cnt increments.
REQ-021 WR_DATA + done_sl: for addr 0-6, write reg[addr] <= data_rx_sl, pulse wr_strobe one cycle later, and set wr_addr=addr.
REQ-022 WR_DATA + done_sl: for addr 7, perform no write and no strobe, and increment err_cnt.
REQ-023 WR_DATA + done_sl: addr increments mod 8 (7 -> 0) and the state stays WR_DATA (burst).
REQ-024 RD_DATA + done_sl: the received byte is ignored; addr increments mod 8; data_tx_sl <= reg[addr+1] on the next edge; the state stays RD_DATA (burst).
REQ-025 DISCARD SHALL ignore all done_sl pulses until the frame ends.
REQ-026 cs=1 in any state SHALL force the next state to IDLE and set data_tx_sl <= 8'h00.
REQ-027 done_sl and cs=1 in the same cycle: the byte SHALL be discarded, with no write, no strobe and no err_cnt change.
REQ-028 SPI write to reg[a] and loc_addr=a in the same cycle: loc_rdata SHALL show the old value and show the new value from the next cycle.
REQ-029 err_cnt SHALL saturate at 8'hFF and not wrap.
REQ-030 data_tx_sl SHALL be registered and change only on the edge after done_sl or on cs deassertion; at all other times it is stable.
REQ-031 done_sl received in IDLE while cs=1 SHALL be ignored.

Reset
REQ-032 While reset=1: state=IDLE, reg[0..6]=RESET_VAL, data_tx_sl=8'h00, wr_strobe=0, wr_addr=0, err_cnt=0, frame_active=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately; after release the block waits in IDLE for a new command byte.

Verification
REQ-034 Write burst: cs=0, bytes 8'h82, 8'h11, 8'h22, cs=1 -> reg2=11, reg3=22, two wr_strobe pulses with wr_addr 2 then 3, err_cnt=0.
REQ-035 Read with wrap: after REQ-034, cs=0, bytes 8'h06, x, x -> data_tx_sl sequence reg6, reg7=DEV_ID(A5), reg0=RESET_VAL; after cs=1, data_tx_sl=00.
REQ-036 Errors: command 8'h48 -> DISCARD, err_cnt=1, following bytes ignored; write command 8'h87 then 8'h55 -> reg7 stays A5, err_cnt=2, no strobe.
REQ-037 Abort: cs=0, 8'h81, then cs=1 coincident with done_sl carrying 8'h33 -> reg1 unchanged, no strobe, state IDLE.
REQ-038 Reset: assert reset during WR_DATA -> all registers at RESET_VAL, err_cnt=0, frame_active=0; the next frame 8'h80, 8'h7E writes reg0=7E.
REQ-039 Saturation: 300 invalid command frames -> err_cnt=FF.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI-side register file: 7 read/write registers plus a fixed device ID at address 7,
// accessed through command/data frames delivered byte-by-byte by an SPI slave core.
module spi_slave_regfile #(
    parameter logic [7:0] DEV_ID    = 8'hA5,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       done_sl,
    input  logic [7:0] data_rx_sl,
    output logic [7:0] data_tx_sl,
    input  logic [2:0] loc_addr,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [2:0] wr_addr,
    output logic [7:0] err_cnt,
    output logic       frame_active,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_DATA = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] addr;
    logic [2:0] addr_next;
    logic [7:0] regs [8];

    assign addr_next    = addr + 3'd1;
    assign loc_rdata    = regs[loc_addr];
    assign frame_active = (state != IDLE);
    assign fsm_state    = state;

    // Entry 7 is loaded with DEV_ID at reset and is never written, so it reads as a constant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= 3'd0;
            data_tx_sl <= 8'h00;
            wr_strobe  <= 1'b0;
            wr_addr    <= 3'd0;
            err_cnt    <= 8'h00;
            for (int i = 0; i < 7; i++) begin
                regs[i] <= RESET_VAL;
            end
            regs[7] <= DEV_ID;
        end else begin
            wr_strobe <= 1'b0;
            if (cs) begin
                // Frame end wins over a coincident byte: it is dropped without side effects.
                state      <= IDLE;
                data_tx_sl <= 8'h00;
            end else if (done_sl) begin
                case (state)
                    IDLE: begin
                        if (data_rx_sl[6:3] != 4'd0) begin
                            state <= DISCARD;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end else begin
                            addr <= data_rx_sl[2:0];
                            if (data_rx_sl[7]) begin
                                state <= WR_DATA;
                            end else begin
                                state      <= RD_DATA;
                                data_tx_sl <= regs[data_rx_sl[2:0]];
                            end
                        end
                    end
                    WR_DATA: begin
                        if (addr != 3'd7) begin
                            regs[addr] <= data_rx_sl;
                            wr_strobe  <= 1'b1;
                            wr_addr    <= addr;
                        end else if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        addr <= addr_next;
                    end
                    RD_DATA: begin
                        addr       <= addr_next;
                        data_tx_sl <= regs[addr_next];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: directed frames, a write-strobe scoreboard,
// reset abort and error-counter saturation.
module tb_spi_slave_regfile;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b1;
    logic       done_sl = 1'b0;
    logic [7:0] data_rx_sl = 8'h00;
    logic [7:0] data_tx_sl;
    logic [2:0] loc_addr = 3'd0;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic [7:0] err_cnt;
    logic       frame_active;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    localparam logic [1:0] S_IDLE = 2'd0, S_WR = 2'd1, S_RD = 2'd2, S_DISC = 2'd3;

    spi_slave_regfile #(.DEV_ID(8'hA5), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .cs(cs), .done_sl(done_sl), .data_rx_sl(data_rx_sl),
        .data_tx_sl(data_tx_sl), .loc_addr(loc_addr), .loc_rdata(loc_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err_cnt(err_cnt),
        .frame_active(frame_active), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard for write strobes
    always @(negedge clk) begin
        if (!reset && wr_strobe) begin
            if (exp_q.size() == 0) begin
                chk("wr_strobe_unexpected", 16'd1, 16'd0);
            end else begin
                chk("wr_addr", {13'd0, wr_addr}, {13'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        done_sl    = 1'b1;
        data_rx_sl = b;
        @(negedge clk);
        done_sl    = 1'b0;
        data_rx_sl = $urandom_range(0, 255);
    endtask

    task automatic begin_frame();
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reg(input logic [2:0] a, input logic [7:0] exp, input string tag);
        loc_addr = a;
        #1;
        chk(tag, {8'd0, loc_rdata}, {8'd0, exp});
    endtask

    initial begin
        logic [7:0] cmd;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_tx", {8'd0, data_tx_sl}, 16'h0000);
        chk("rst_strobe", {15'd0, wr_strobe}, 16'd0);
        chk("rst_wr_addr", {13'd0, wr_addr}, 16'd0);
        chk("rst_err", {8'd0, err_cnt}, 16'd0);
        chk("rst_active", {15'd0, frame_active}, 16'd0);
        for (int i = 0; i < 8; i++) chk_reg(i[2:0], (i == 7) ? 8'hA5 : 8'h00, "rst_reg");
        @(negedge clk);
        reset = 1'b0;

        // write burst 82, 11, 22
        begin_frame();
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        send_byte(8'h82);
        chk("wr_state", {14'd0, fsm_state}, {14'd0, S_WR});
        chk("wr_active", {15'd0, frame_active}, 16'd1);
        send_byte(8'h11);
        // same-cycle local read sees old value, then new value
        @(negedge clk);
        done_sl = 1'b1;
        data_rx_sl = 8'h22;
        chk_reg(3'd3, 8'h00, "coll_old");
        @(negedge clk);
        done_sl = 1'b0;
        chk_reg(3'd3, 8'h22, "coll_new");
        end_frame();
        chk_reg(3'd2, 8'h11, "reg2");
        chk("wr_err", {8'd0, err_cnt}, 16'd0);
        chk("wr_end_active", {15'd0, frame_active}, 16'd0);

        // give reg6 a distinctive value, then read 6,7,0 with wrap
        begin_frame();
        exp_q.push_back(3'd6);
        send_byte(8'h86);
        send_byte(8'h66);
        end_frame();
        begin_frame();
        send_byte(8'h06);
        chk("rd_state", {14'd0, fsm_state}, {14'd0, S_RD});
        chk("rd_tx6", {8'd0, data_tx_sl}, 16'h0066);
        repeat (3) @(negedge clk);
        chk("rd_tx_stable", {8'd0, data_tx_sl}, 16'h0066);
        send_byte(8'hC3);
        chk("rd_tx7", {8'd0, data_tx_sl}, 16'h00A5);
        send_byte(8'h5A);
        chk("rd_tx0", {8'd0, data_tx_sl}, 16'h0000);
        send_byte(8'hFF);
        chk("rd_tx1", {8'd0, data_tx_sl}, 16'h0000);
        end_frame();
        chk("rd_tx_cs", {8'd0, data_tx_sl}, 16'h0000);

        // invalid command then ignored bytes
        begin_frame();
        send_byte(8'h48);
        chk("disc_state", {14'd0, fsm_state}, {14'd0, S_DISC});
        chk("disc_err", {8'd0, err_cnt}, 16'd1);
        send_byte(8'h82);
        send_byte(8'h99);
        end_frame();
        chk("disc_err_hold", {8'd0, err_cnt}, 16'd1);
        chk_reg(3'd2, 8'h11, "disc_reg2");

        // write to addr 7 is rejected, burst wraps to 0
        begin_frame();
        exp_q.push_back(3'd0);
        send_byte(8'h87);
        send_byte(8'h55);
        chk("wr7_err", {8'd0, err_cnt}, 16'd2);
        send_byte(8'h5A);
        end_frame();
        chk_reg(3'd7, 8'hA5, "wr7_reg7");
        chk_reg(3'd0, 8'h5A, "wrap_reg0");

        // abort: cs rises with done_sl in the same cycle
        begin_frame();
        send_byte(8'h81);
        @(negedge clk);
        cs = 1'b1;
        done_sl = 1'b1;
        data_rx_sl = 8'h33;
        @(negedge clk);
        done_sl = 1'b0;
        chk_reg(3'd1, 8'h00, "abort_reg1");
        chk("abort_state", {14'd0, fsm_state}, {14'd0, S_IDLE});
        chk("abort_err", {8'd0, err_cnt}, 16'd2);

        // done_sl in IDLE with cs high is ignored
        @(negedge clk);
        done_sl = 1'b1;
        data_rx_sl = 8'h48;
        @(negedge clk);
        done_sl = 1'b0;
        chk("idle_cs_state", {14'd0, fsm_state}, {14'd0, S_IDLE});
        chk("idle_cs_err", {8'd0, err_cnt}, 16'd2);

        // reset mid-frame
        begin_frame();
        send_byte(8'h80);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_active", {15'd0, frame_active}, 16'd0);
        chk("arst_err", {8'd0, err_cnt}, 16'd0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk_reg(i[2:0], (i == 7) ? 8'hA5 : 8'h00, "arst_reg");
        reset = 1'b0;
        cs = 1'b1;
        @(negedge clk);
        chk("arst_idle", {14'd0, fsm_state}, {14'd0, S_IDLE});
        begin_frame();
        exp_q.push_back(3'd0);
        send_byte(8'h80);
        send_byte(8'h7E);
        end_frame();
        chk_reg(3'd0, 8'h7E, "post_rst_reg0");

        // error counter saturation
        for (int f = 1; f <= 300; f++) begin
            cmd = {1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 3'($urandom_range(0, 7))};
            begin_frame();
            send_byte(cmd);
            end_frame();
            if (f == 10) chk("sat_err10", {8'd0, err_cnt}, 16'd10);
            if (f == 255) chk("sat_err255", {8'd0, err_cnt}, 16'h00FF);
        end
        chk("sat_err300", {8'd0, err_cnt}, 16'h00FF);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
